// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: owns the fetch PC, the req/ack instruction-memory port and the
// IF/ID register; applies stall/flush/redirect controls from the hazard unit.
module fetch_stage_ctrl #(
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      RESET_PC  = '0,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic [1:0]      pcsrcE,
  input  logic [XLEN-1:0] pctargetE,
  input  logic [XLEN-1:0] pcjalrE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pcplus4D,
  output logic            validD,
  output logic            fetch_busy
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_KILL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       ibuf_instr_q, ibuf_instr_d;
  logic [XLEN-1:0]   ibuf_pc_q, ibuf_pc_d;
  logic [XLEN-1:0]   killaddr_q, killaddr_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   pcd_q, pcd_d;
  logic [XLEN-1:0]   pcplus4_q, pcplus4_d;
  logic              valid_q, valid_d;

  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              avail;
  logic [31:0]       avail_instr;
  logic [XLEN-1:0]   avail_pc;

  assign redirect    = (pcsrcE != 2'b00);
  assign redirect_pc = (pcsrcE == 2'b01) ? pctargetE : pcjalrE;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ibuf_instr_d = ibuf_instr_q;
    ibuf_pc_d    = ibuf_pc_q;
    killaddr_d   = killaddr_q;
    avail        = 1'b0;
    avail_instr  = imem_rdata;
    avail_pc     = pc_q;

    unique case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // An unanswered request must still be drained at its original address.
          if (!imem_ack) begin
            killaddr_d = pc_q;
            state_d    = S_KILL;
          end
        end else if (imem_ack) begin
          if (stallF) begin
            ibuf_instr_d = imem_rdata;
            ibuf_pc_d    = pc_q;
            state_d      = S_HOLD;
          end else begin
            avail = 1'b1;
            pc_d  = pc_q + XLEN'(4);
          end
        end
      end
      S_HOLD: begin
        avail_instr = ibuf_instr_q;
        avail_pc    = ibuf_pc_q;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (!stallF) begin
          avail   = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          state_d = S_FETCH;
        end
      end
      S_KILL: begin
        if (redirect) pc_d = redirect_pc;
        if (imem_ack) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (flushD || (!stallD && !avail)) begin
      instr_d   = NOP_INSTR;
      pcd_d     = '0;
      pcplus4_d = '0;
      valid_d   = 1'b0;
    end else if (!stallD) begin
      instr_d   = avail_instr;
      pcd_d     = avail_pc;
      pcplus4_d = avail_pc + XLEN'(4);
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ibuf_instr_q <= '0;
      ibuf_pc_q    <= '0;
      killaddr_q   <= '0;
      instr_q      <= NOP_INSTR;
      pcd_q        <= '0;
      pcplus4_q    <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ibuf_instr_q <= ibuf_instr_d;
      ibuf_pc_q    <= ibuf_pc_d;
      killaddr_q   <= killaddr_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      pcplus4_q    <= pcplus4_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req   = ~rst & (state_q != S_HOLD);
  assign imem_addr  = (state_q == S_KILL) ? killaddr_q : pc_q;
  assign fetch_busy = ((state_q == S_FETCH) & ~imem_ack) | (state_q == S_KILL);
  assign instrD     = instr_q;
  assign pcD        = pcd_q;
  assign pcplus4D   = pcplus4_q;
  assign validD     = valid_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: an abstract fetch model (next PC,
// captured instruction, doomed outstanding request) is checked every cycle.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0;
  logic [1:0]  pcsrcE = 2'b00;
  logic [31:0] pctargetE = '0, pcjalrE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instrD, pcD, pcplus4D;
  logic        validD, fetch_busy;

  fetch_stage_ctrl #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushD     (flushD),
    .pcsrcE     (pcsrcE),
    .pctargetE  (pctargetE),
    .pcjalrE    (pcjalrE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instrD     (instrD),
    .pcD        (pcD),
    .pcplus4D   (pcplus4D),
    .validD     (validD),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  // Memory contents are a simple function of the address.
  assign imem_rdata = 32'hC0DE_0000 + imem_addr;

  int n_cmp = 0;
  int n_err = 0;

  // Abstract model state
  bit          m_known = 1'b0;
  logic [31:0] m_pc;
  bit          m_have;
  logic [31:0] m_have_instr, m_have_pc;
  bit          m_doomed;
  logic [31:0] m_doomed_addr;
  logic [31:0] m_instr, m_pcd, m_p4;
  bit          m_valid, m_pc_known;

  // Hand-computed literal expectations for the next step
  bit          l_if = 0, l_pc = 0, l_ad = 0;
  logic [31:0] l_instr, l_pcv, l_p4, l_addr;
  bit          l_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic lit_if(input logic [31:0] instr, input bit valid);
    l_if = 1; l_instr = instr; l_valid = valid;
  endtask
  task automatic lit_pc(input logic [31:0] pc, input logic [31:0] p4);
    l_pc = 1; l_pcv = pc; l_p4 = p4;
  endtask
  task automatic lit_ad(input logic [31:0] a);
    l_ad = 1; l_addr = a;
  endtask

  task automatic step(input bit r, input bit sf, input bit sd, input bit fd,
                      input logic [1:0] ps, input logic [31:0] tgt,
                      input logic [31:0] jalr, input bit ack);
    bit          redir, took;
    logic [31:0] newpc, rd, t_instr, t_pc;
    @(negedge clk);
    rst = r; stallF = sf; stallD = sd; flushD = fd;
    pcsrcE = ps; pctargetE = tgt; pcjalrE = jalr; imem_ack = ack;
    #1;
    rd = imem_rdata;

    if (r) chk("req_in_reset", {31'd0, imem_req}, 32'd0);
    else if (m_known) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, !m_have});
      if (!m_have) chk("imem_addr", imem_addr, m_doomed ? m_doomed_addr : m_pc);
      chk("fetch_busy", {31'd0, fetch_busy},
          {31'd0, m_doomed || (!m_have && !ack)});
    end
    if (m_known) begin
      chk("instrD", instrD, m_instr);
      chk("validD", {31'd0, validD}, {31'd0, m_valid});
      if (m_pc_known) begin
        chk("pcD", pcD, m_pcd);
        chk("pcplus4D", pcplus4D, m_p4);
      end
    end
    if (l_if) begin
      chk("lit_instrD", instrD, l_instr);
      chk("lit_validD", {31'd0, validD}, {31'd0, l_valid});
    end
    if (l_pc) begin
      chk("lit_pcD", pcD, l_pcv);
      chk("lit_pcplus4D", pcplus4D, l_p4);
    end
    if (l_ad) chk("lit_imem_addr", imem_addr, l_addr);
    l_if = 0; l_pc = 0; l_ad = 0;

    // Model advance for this clock edge
    if (r) begin
      m_known = 1; m_pc = 32'h0; m_have = 0; m_doomed = 0;
      m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 0; m_pc_known = 1;
      return;
    end
    redir = (ps != 2'b00);
    newpc = (ps == 2'b01) ? tgt : jalr;
    took = 0; t_instr = rd; t_pc = m_pc;
    if (m_doomed) begin
      if (ack) m_doomed = 0;
      if (redir) m_pc = newpc;
    end else if (m_have) begin
      t_instr = m_have_instr; t_pc = m_have_pc;
      if (redir) begin m_have = 0; m_pc = newpc; end
      else if (!sf) begin took = 1; m_have = 0; m_pc = m_pc + 32'd4; end
    end else if (redir) begin
      if (!ack) begin m_doomed = 1; m_doomed_addr = m_pc; end
      m_pc = newpc;
    end else if (ack) begin
      if (sf) begin m_have = 1; m_have_instr = rd; m_have_pc = m_pc; end
      else begin took = 1; m_pc = m_pc + 32'd4; end
    end

    if (fd) begin
      m_instr = NOP; m_valid = 0; m_pcd = 0; m_p4 = 0; m_pc_known = 1;
    end else if (sd) begin
      // hold
    end else if (took) begin
      m_instr = t_instr; m_valid = 1; m_pcd = t_pc; m_p4 = t_pc + 32'd4; m_pc_known = 1;
    end else begin
      m_instr = NOP; m_valid = 0; m_pc_known = 0;
    end
  endtask

  initial begin
    // Reset, then zero-wait memory
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    lit_if(NOP, 0); lit_pc(0, 0);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    lit_ad(32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_if(32'hC0DE_0000, 1); lit_pc(32'h0, 32'h4);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_pc(32'h4, 32'h8);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_pc(32'h8, 32'hC);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_if(32'hC0DE_000C, 1); lit_pc(32'hC, 32'h10);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);

    // Two wait states at pc 0
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);
    lit_if(NOP, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);
    lit_if(NOP, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_if(32'hC0DE_0000, 1); lit_pc(32'h0, 32'h4);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);

    // Load-use stall while the fetch of 8 completes
    lit_ad(32'h8);
    step(0, 1, 1, 0, 2'b00, 0, 0, 1);
    lit_if(32'hC0DE_0004, 1); lit_pc(32'h4, 32'h8);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);
    lit_if(32'hC0DE_0008, 1); lit_pc(32'h8, 32'hC); lit_ad(32'hC);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);

    // Branch with flush during an acked fetch of 0x10
    lit_ad(32'h10);
    step(0, 0, 0, 1, 2'b01, 32'h40, 0, 1);
    lit_if(NOP, 0); lit_pc(0, 0); lit_ad(32'h40);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_if(32'hC0DE_0040, 1); lit_pc(32'h40, 32'h44);
    step(0, 0, 0, 1, 2'b01, 32'h10, 0, 1);

    // JALR redirect while the fetch of 0x10 is pending
    lit_ad(32'h10);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 1, 2'b10, 0, 32'h80, 0);
    lit_ad(32'h10); lit_if(NOP, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);
    lit_ad(32'h10);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_ad(32'h80); lit_if(NOP, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_if(32'hC0DE_0080, 1); lit_pc(32'h80, 32'h84);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);

    // Redirect while holding a captured instruction
    step(0, 1, 1, 0, 2'b00, 0, 0, 1);
    lit_if(32'hC0DE_0084, 1); lit_pc(32'h84, 32'h88);
    step(0, 1, 0, 1, 2'b01, 32'h20, 0, 0);
    lit_if(NOP, 0); lit_ad(32'h20);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_if(32'hC0DE_0020, 1); lit_pc(32'h20, 32'h24);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);

    // Reset in the middle of a pending request
    lit_ad(32'h24);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    lit_ad(32'h0); lit_if(NOP, 0); lit_pc(0, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_if(32'hC0DE_0000, 1); lit_pc(32'h0, 32'h4);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);

    // pcsrcE=11 selects the jalr target; PC+4 wraps at the top of memory
    lit_ad(32'h4);
    step(0, 0, 0, 1, 2'b11, 32'h40, 32'hFFFF_FFFC, 1);
    lit_ad(32'hFFFF_FFFC);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_if(32'hC0DD_FFFC, 1); lit_pc(32'hFFFF_FFFC, 32'h0); lit_ad(32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1);
    lit_ad(32'h4);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
Fetch-side consumer of the pipeline hazard controls. It owns the fetch PC, drives a req/ack instruction-memory port, and owns the IF/ID pipeline register. It applies stallF/stallD/flushD and pcsrcE redirects exactly as the hazard logic issues them. It raises fetch_busy when memory is slow, so that condition is ORed into stallF/stallD at the top level.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on bubble/flush (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
stallF  input  1  hold fetch PC
stallD  input  1  hold IF/ID register
flushD  input  1  clear IF/ID to bubble
pcsrcE  input  2  00 sequential, 01 branch/jal target, 10 jalr target, 11 treated as 10
pctargetE  input  XLEN  branch/jal target
pcjalrE  input  XLEN  jalr target
imem_req  output  1  fetch request
imem_addr  output  XLEN  fetch address, stable while imem_req=1 and imem_ack=0
imem_ack  input  1  response valid, same cycle as imem_req or later
imem_rdata  input  32  instruction, valid when imem_ack=1
instrD  output  32  IF/ID instruction
pcD  output  XLEN  IF/ID PC
pcplus4D  output  XLEN  IF/ID PC+4
validD  output  1  IF/ID holds a real instruction
fetch_busy  output  1  fetch has no instruction this cycle (combinational)

Behaviour:
- Reset: pcF=RESET_PC; state=FETCH; instrD=NOP_INSTR; pcD=0; pcplus4D=0; validD=0; ibuf cleared; imem_req=0 during the reset cycle. imem is reset with the same rst, so no stale ack survives reset. Reset mid-request abandons the request.
- Redirect = (pcsrcE!=00). It has priority over every stall. pcF <= selected target (01 pctargetE, else pcjalrE). PC+4 arithmetic wraps modulo 2^XLEN.
- IF/ID update, priority order:
  - flushD: instrD=NOP_INSTR, validD=0, pcD/pcplus4D=0.
  - stallD: hold all fields.
  - Instruction available and no redirect: load {instr, addr, addr+4}, validD=1.
  - Otherwise: load bubble (NOP_INSTR, validD=0).
- States:
  - FETCH: imem_req=1, imem_addr=pcF.
    - ack=1, no stall, no redirect: deliver rdata to IF/ID; pcF<=pcF+4; stay in FETCH (one instruction per cycle with zero-wait memory).
    - ack=1, stallF=1: capture rdata and pcF into ibuf; go to HOLD; pcF unchanged.
    - ack=0: fetch_busy=1; pcF unchanged.
    - Redirect with ack=1: discard rdata; load new pcF; stay in FETCH.
    - Redirect with ack=0: latch the old address as killaddr; load new pcF; go to KILL.
  - HOLD: imem_req=0; fetch_busy=0.
    - stallF=0: deliver ibuf to IF/ID; pcF<=pcF+4; go to FETCH.
    - Redirect: discard ibuf; load new pcF; go to FETCH.
  - KILL: imem_req=1, imem_addr=killaddr; fetch_busy=1.
    - On ack: discard rdata; go to FETCH (new pcF is requested next cycle).
    - Further redirects only update pcF.
- Simultaneous flushD and stallD: flush wins.
- Simultaneous redirect and stallF: redirect wins.
- A response never reaches IF/ID after a redirect that precedes its ack.
- imem_addr never changes while a request is pending without ack, including in KILL.
- fetch_busy = (FETCH & ~imem_ack) | KILL.

Test Plan:
- Zero-wait memory: release reset, ack tied 1, rdata = addr-based pattern. Required: pcD = 0,4,8,C on consecutive cycles after the first valid cycle, validD=1, imem_req=0 during reset.
- Two-wait-state memory at pc 0: fetch_busy=1 for 2 cycles; IF/ID receives bubbles (validD=0, instrD=0x00000013); next cycle instrD=rdata@0, pcD=0, pcplus4D=4.
- lwstall: one-cycle stallF=stallD=1 while ack=1 at pc 8. Required: IF/ID holds, state goes to HOLD with imem_req=0; next cycle instrD=rdata@8, pcD=8, then imem_addr=0xC.
- Branch pcsrcE=01, pctargetE=0x40, flushD=1 during a fetch with ack=1. Required: next cycle instrD=NOP, validD=0; following request imem_addr=0x40; rdata from the old address never appears.
- JALR redirect pcsrcE=10, pcjalrE=0x80 during a pending fetch of 0x10. Required: imem_addr stays 0x10 until ack; that rdata is discarded; next request is 0x80; fetch_busy=1 throughout KILL.
- Redirect while in HOLD (stallF=1, pcsrcE=01, pctargetE=0x20). Required: ibuf is discarded, IF/ID is flushed, next imem_addr=0x20.
- Mid-request reset: assert rst while ack=0. Required: all outputs return to reset values, and the first request after reset is to RESET_PC.
